// File: rtl/rf_scoreboard.sv
// rf_scoreboard: multi-read-port register file with per-register pending-write scoreboard
//   Ports: clk, rst (async active-low); rd_addr/rd_data/rd_busy (NRD combinational read ports);
//   wr_en/wr_addr/wr_data (writeback); alloc_en/alloc_addr/alloc_stall (producer issue);
//   flush (clear all pending counters). Optional same-cycle write bypass: define RF_BYPASS_EN.
module rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  output logic                  alloc_stall,
  input  logic                  flush
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] pend [DEPTH];
  logic wrHit, decEn, allocHit, incEn;
  // entry 0 and pend[0] stay at their reset value of 0, so x0 reads as 0 / not busy
  assign wrHit = wr_en && wr_addr != '0;
  assign decEn = wrHit && pend[wr_addr] != '0;
  assign allocHit = alloc_en && alloc_addr != '0;
  // a full counter can still accept a new producer if one retires in the same cycle
  assign alloc_stall = allocHit && pend[alloc_addr] == {CNT_W{1'b1}} && !(decEn && wr_addr == alloc_addr);
  assign incEn = allocHit && !alloc_stall;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        pend[i] <= '0;
      end
    else
      for (int i = 1; i < DEPTH; i++) begin
        if (wrHit && wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
        pend[i] <= flush ? '0 : pend[i] + CNT_W'(incEn && alloc_addr == ADDR_W'(i)) - CNT_W'(decEn && wr_addr == ADDR_W'(i));
      end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic byp;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    assign byp = wrHit && wr_addr == a;
`else
    assign byp = 1'b0;
`endif
    // a bypassed read sees the write's data and the counter as if already decremented
    assign rd_data[k*DATA_W +: DATA_W] = byp ? wr_data : mem[a];
    assign rd_busy[k] = byp ? pend[a] > CNT_W'(1) : pend[a] != '0;
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: randomized and directed checks of rf_scoreboard against a behavioural model
module tb_rf_scoreboard;
  localparam int DW = 32, AW = 5, NRD = 2, CW = 2;
  localparam int DEPTH = 1 << AW, MAXC = (1 << CW) - 1;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic [NRD*AW-1:0] rdAddr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic wrEn, allocEn, flush, alloc_stall;
  logic [AW-1:0] wrAddr, allocAddr;
  logic [DW-1:0] wrData;
  logic [DW-1:0] refMem [DEPTH];
  int refPend [DEPTH];
  int errCnt = 0, chkCnt = 0;

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .alloc_en(allocEn), .alloc_addr(allocAddr), .alloc_stall(alloc_stall), .flush(flush));

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setIn(input bit we, input int wa, input logic [DW-1:0] wd, input bit ae, input int aa, input bit fl);
    wrEn = we; wrAddr = AW'(wa); wrData = wd; allocEn = ae; allocAddr = AW'(aa); flush = fl;
  endtask

  task automatic setRd(input int a0, input int a1);
    rdAddr = {AW'(a1), AW'(a0)};
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i] = '0;
      refPend[i] = 0;
    end
  endtask

  // refusal only when the target is saturated and nothing of its own retires this cycle
  function automatic bit expStall();
    return allocEn && allocAddr != 0 && refPend[allocAddr] == MAXC && !(wrEn && wrAddr == allocAddr);
  endfunction

  task automatic checkOutputs();
    for (int k = 0; k < NRD; k++) begin
      int a;
      bit byp;
      a = int'(rdAddr[k*AW +: AW]);
      byp = BYP && wrEn && wrAddr != 0 && int'(wrAddr) == a;
      checkVal($sformatf("rdData%0d@x%0d", k, a), 64'(rd_data[k*DW +: DW]), 64'(byp ? wrData : refMem[a]));
      checkVal($sformatf("rdBusy%0d@x%0d", k, a), 64'(rd_busy[k]), 64'(byp ? refPend[a] > 1 : refPend[a] != 0));
    end
    checkVal("allocStall", 64'(alloc_stall), 64'(expStall()));
  endtask

  // check combinational outputs mid-cycle, take the edge, then advance the model
  task automatic cycle();
    bit inc, dec;
    #1 checkOutputs();
    inc = allocEn && allocAddr != 0 && !expStall();
    dec = wrEn && wrAddr != 0 && refPend[wrAddr] > 0;
    @(posedge clk);
    if (wrEn && wrAddr != 0) refMem[wrAddr] = wrData;
    if (flush) for (int i = 0; i < DEPTH; i++) refPend[i] = 0;
    else begin
      if (dec) refPend[wrAddr]--;
      if (inc) refPend[allocAddr]++;
    end
    @(negedge clk);
  endtask

  initial begin
    clearModel();
    rst = 1'b1;
    setIn(0, 0, '0, 0, 0, 0);
    setRd(3, 3);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("rstData", 64'(rd_data), 64'(0));
    checkVal("rstBusy", 64'(rd_busy), 64'(0));
    checkVal("rstStall", 64'(alloc_stall), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    setIn(1, 3, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    setIn(0, 0, '0, 0, 0, 0);
    #1 checkVal("x3Data", 64'(rd_data[DW-1:0]), 64'h0DEADBEEF);
    cycle();

    setRd(0, 0);
    setIn(1, 0, 32'h1234, 1, 0, 0);
    #1 checkVal("x0Stall", 64'(alloc_stall), 64'(0));
    cycle();
    setIn(0, 0, '0, 0, 0, 0);
    #1 checkVal("x0Data", 64'(rd_data), 64'(0));
    checkVal("x0Busy", 64'(rd_busy), 64'(0));
    cycle();

    setRd(0, 5);
    setIn(1, 5, 32'h11111111, 0, 0, 0);
    cycle();
    setIn(1, 5, 32'hA5A5A5A5, 0, 0, 0);
    #1 checkVal("bypSame", 64'(rd_data[DW +: DW]), BYP ? 64'hA5A5A5A5 : 64'h11111111);
    cycle();
    setIn(0, 0, '0, 0, 0, 0);
    #1 checkVal("bypNext", 64'(rd_data[DW +: DW]), 64'hA5A5A5A5);
    cycle();

    setRd(7, 7);
    setIn(0, 0, '0, 1, 7, 0);
    cycle();
    #1 checkVal("x7Busy1", 64'(rd_busy[0]), 64'(1));
    repeat (2) cycle();
    #1 checkVal("x7Stall4", 64'(alloc_stall), 64'(1));
    cycle();
    setIn(1, 7, 32'h77, 1, 7, 0);
    #1 checkVal("x7NoStallWb", 64'(alloc_stall), 64'(0));
    cycle();
    setIn(0, 0, '0, 1, 7, 0);
    #1 checkVal("x7StillFull", 64'(alloc_stall), 64'(1));
    setIn(1, 7, 32'h78, 0, 0, 0);
    repeat (3) cycle();
    setIn(0, 0, '0, 0, 0, 0);
    #1 checkVal("x7BusyClr", 64'(rd_busy[0]), 64'(0));
    cycle();

    setRd(2, 9);
    setIn(0, 0, '0, 1, 2, 0);
    cycle();
    setIn(0, 0, '0, 1, 9, 0);
    cycle();
    #1 checkVal("preFlushBusy", 64'(rd_busy), 64'(3));
    setIn(0, 0, '0, 1, 4, 1);
    cycle();
    setIn(0, 0, '0, 0, 0, 0);
    #1 checkVal("flushBusy", 64'(rd_busy), 64'(0));
    setRd(4, 2);
    #1 checkVal("flushX4", 64'(rd_busy[0]), 64'(0));
    setIn(1, 2, 32'h2222, 0, 0, 0);
    cycle();
    setIn(0, 0, '0, 0, 0, 0);
    #1 checkVal("postFlushWb", 64'(rd_data[DW +: DW]), 64'h2222);
    checkVal("postFlushBusy", 64'(rd_busy[1]), 64'(0));
    cycle();

    for (int n = 0; n < 400; n++) begin
      setRd($urandom_range(0, 7), $urandom_range(0, 7));
      setIn(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 15) == 0);
      cycle();
    end

    setIn(1, 3, 32'hCAFEF00D, 1, 3, 0);
    cycle();
    setIn(0, 0, '0, 1, 3, 0);
    repeat (3) cycle();
    setRd(3, 3);
    #1 checkVal("preRstStall", 64'(alloc_stall), 64'(1));
    #1 rst = 1'b0;
    #1 checkVal("midRstData", 64'(rd_data), 64'(0));
    checkVal("midRstBusy", 64'(rd_busy), 64'(0));
    checkVal("midRstStall", 64'(alloc_stall), 64'(0));
    clearModel();
    setIn(0, 0, '0, 0, 0, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    cycle();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
